// File: rtl/ucsbece154b_issue_buffer.sv
// Dual-issue instruction buffer: circular {instr, pc} store between fetch and the two decode slots.
// Accepts aligned pairs, presents the two oldest entries, and retires 0, 1 or 2 entries per cycle.
module ucsbece154b_issue_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     FetchValid_i,
  input  logic [31:0]              FetchPC_i,
  input  logic [31:0]              FetchInstr1_i,
  input  logic [31:0]              FetchInstr2_i,
  output logic                     FetchReady_o,
  input  logic                     Flush_i,
  input  logic                     StallD_i,
  input  logic                     Slot2Hold_i,
  output logic [31:0]              InstrD1_o,
  output logic [31:0]              InstrD2_o,
  output logic [31:0]              PCD1_o,
  output logic [31:0]              PCD2_o,
  output logic                     ValidD1_o,
  output logic                     ValidD2_o,
  output logic [$clog2(DEPTH):0]   Count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [AW-1:0] head_1, tail_1;
  logic          valid1, valid2, push;
  logic [1:0]    pop;
  logic [CW-1:0] count_next;

  // Handshake: a pair transfers on an edge where FetchValid_i and FetchReady_o are both
  // high and no flush is pending; FetchReady_o comes from the registered count only, so
  // fetch must hold and re-present a pair offered while ready is low.
  always_comb begin
    head_1       = head + AW'(1);
    tail_1       = tail + AW'(1);
    valid1       = (count != '0);
    valid2       = (count > CW'(1));
    FetchReady_o = (count <= CW'(DEPTH - 2));
    push         = FetchValid_i & FetchReady_o & ~Flush_i;

    // Load-use stall outranks the slot-2 hazard.
    pop = 2'd0;
    if (StallD_i || !valid1) pop = 2'd0;
    else if (Slot2Hold_i || !valid2) pop = 2'd1;
    else pop = 2'd2;

    count_next = count + (push ? CW'(2) : CW'(0)) - CW'(pop);
  end

  always_comb begin
    ValidD1_o = valid1;
    ValidD2_o = valid2;
    InstrD1_o = valid1 ? instr_mem[head]   : NOP;
    PCD1_o    = valid1 ? pc_mem[head]      : 32'h0;
    InstrD2_o = valid2 ? instr_mem[head_1] : NOP;
    PCD2_o    = valid2 ? pc_mem[head_1]    : 32'h0;
    Count_o   = count;
  end

  always_ff @(posedge clk) begin
    if (reset || Flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop);
      count <= count_next;
      if (push) tail <= tail + AW'(2);
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_mem[tail]   <= FetchInstr1_i;
      pc_mem[tail]      <= FetchPC_i;
      instr_mem[tail_1] <= FetchInstr2_i;
      pc_mem[tail_1]    <= FetchPC_i + 32'd4;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_issue_buffer.sv
// Directed bench for ucsbece154b_issue_buffer: hand-computed slot, count and ready values.
module tb_ucsbece154b_issue_buffer;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc, fetch_instr1, fetch_instr2;
  logic        fetch_ready;
  logic        flush, stall_d, slot2_hold;
  logic [31:0] instr_d1, instr_d2, pc_d1, pc_d2;
  logic        valid_d1, valid_d2;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;

  ucsbece154b_issue_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .FetchValid_i  (fetch_valid),
    .FetchPC_i     (fetch_pc),
    .FetchInstr1_i (fetch_instr1),
    .FetchInstr2_i (fetch_instr2),
    .FetchReady_o  (fetch_ready),
    .Flush_i       (flush),
    .StallD_i      (stall_d),
    .Slot2Hold_i   (slot2_hold),
    .InstrD1_o     (instr_d1),
    .InstrD2_o     (instr_d2),
    .PCD1_o        (pc_d1),
    .PCD2_o        (pc_d2),
    .ValidD1_o     (valid_d1),
    .ValidD2_o     (valid_d2),
    .Count_o       (count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC0DE_0000 | {16'h0, pc[15:0]};
  endfunction

  // Driver tasks: inputs change 1ns after the rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] pc);
    fetch_valid  = 1'b1;
    fetch_pc     = pc;
    fetch_instr1 = instr_of(pc);
    fetch_instr2 = instr_of(pc + 32'd4);
    step();
    fetch_valid  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) check("count_le_depth", 32'(count <= DEPTH), 32'd1);
  end

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr1 = '0; fetch_instr2 = '0;
    flush = 1'b0; stall_d = 1'b0; slot2_hold = 1'b0;
    step(); step();
    reset = 1'b0;

    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(fetch_ready), 32'd1);
    check("rst_v1", 32'(valid_d1), 32'd0);
    check("rst_v2", 32'(valid_d2), 32'd0);
    check("rst_i1", instr_d1, NOP);
    check("rst_i2", instr_d2, NOP);
    check("rst_pc1", pc_d1, 32'h0);
    check("rst_pc2", pc_d2, 32'h0);

    // Single pair in, then full dual pop
    fetch_valid = 1'b1; fetch_pc = 32'h1000;
    fetch_instr1 = 32'h0050_0093; fetch_instr2 = 32'h0060_0113;
    step();
    fetch_valid = 1'b0;
    check("p1_v1", 32'(valid_d1), 32'd1);
    check("p1_v2", 32'(valid_d2), 32'd1);
    check("p1_pc1", pc_d1, 32'h1000);
    check("p1_pc2", pc_d2, 32'h1004);
    check("p1_i1", instr_d1, 32'h0050_0093);
    check("p1_i2", instr_d2, 32'h0060_0113);
    check("p1_count", 32'(count), 32'd2);
    step();
    check("pop2_count", 32'(count), 32'd0);
    check("pop2_v1", 32'(valid_d1), 32'd0);
    check("pop2_i1", instr_d1, NOP);
    check("pop2_pc1", pc_d1, 32'h0);

    // Slot-2 hold retires only slot 1
    stall_d = 1'b1;
    push_pair(32'h1000);
    push_pair(32'h1008);
    check("fill4_count", 32'(count), 32'd4);
    stall_d = 1'b0; slot2_hold = 1'b1;
    step();
    stall_d = 1'b1;
    check("hold_pc1", pc_d1, 32'h1004);
    check("hold_pc2", pc_d2, 32'h1008);
    check("hold_count", 32'(count), 32'd3);

    // Stall beats hold; push still lands
    push_pair(32'h1010);
    check("stall_count", 32'(count), 32'd5);
    check("stall_pc1", pc_d1, 32'h1004);
    check("stall_pc2", pc_d2, 32'h1008);
    check("stall_i1", instr_d1, instr_of(32'h1004));

    // Push with a single pop, then fill to full
    stall_d = 1'b0;
    push_pair(32'h1018);
    stall_d = 1'b1;
    check("pp_count", 32'(count), 32'd6);
    check("pp_pc1", pc_d1, 32'h1008);
    push_pair(32'h1020);
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(fetch_ready), 32'd0);
    push_pair(32'h1028);
    check("drop_count", 32'(count), 32'd8);
    stall_d = 1'b0;
    step();
    stall_d = 1'b1;
    check("c7_count", 32'(count), 32'd7);
    check("c7_ready", 32'(fetch_ready), 32'd0);
    check("c7_pc1", pc_d1, 32'h100C);

    // Drain across the pointer wrap; last cycle has one entry left
    stall_d = 1'b0; slot2_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc1", pc_d1, 32'h100C + 32'(8 * i));
      check("drain_i1", instr_d1, instr_of(32'h100C + 32'(8 * i)));
      if (i < 3) begin
        check("drain_pc2", pc_d2, 32'h1010 + 32'(8 * i));
      end else begin
        check("c1_v2", 32'(valid_d2), 32'd0);
        check("c1_i2", instr_d2, NOP);
        check("c1_count", 32'(count), 32'd1);
      end
      step();
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_v1", 32'(valid_d1), 32'd0);

    // Flush with simultaneous push and pop
    stall_d = 1'b1;
    push_pair(32'h3000);
    push_pair(32'h3008);
    push_pair(32'h3010);
    stall_d = 1'b0; slot2_hold = 1'b1;
    step();
    slot2_hold = 1'b0;
    check("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1;
    push_pair(32'h3018);
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_v1", 32'(valid_d1), 32'd0);
    stall_d = 1'b1;
    push_pair(32'h2000);
    check("post_flush_v1", 32'(valid_d1), 32'd1);
    check("post_flush_pc1", pc_d1, 32'h2000);
    check("post_flush_pc2", pc_d2, 32'h2004);
    check("post_flush_count", 32'(count), 32'd2);

    // Reset beats flush and empties a non-empty buffer
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0;
    check("rst2_count", 32'(count), 32'd0);
    check("rst2_ready", 32'(fetch_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_issue_buffer.md
# ucsbece154b_issue_buffer

Dual-issue instruction buffer between the instruction-memory fetch port and the two-slot decode stage of the superscalar pipeline. It accepts aligned instruction pairs from fetch and presents the oldest two buffered instructions to decode slots 1 and 2. When the decode controller holds slot 2 because of an intra-pair hazard, the buffer retires only the slot-1 instruction, so the held instruction becomes slot 1 on the next cycle. On a mispredict it discards all contents.

## Interface
- DEPTH, 8, number of entries; power of two, at least 4
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; empties the buffer
- FetchValid_i  in  1  fetch presents an instruction pair this cycle
- FetchPC_i  in  32  PC of the first instruction; the second instruction is at FetchPC_i+4
- FetchInstr1_i  in  32  instruction at FetchPC_i
- FetchInstr2_i  in  32  instruction at FetchPC_i+4
- FetchReady_o  out  1  at least 2 free entries exist (Count_o <= DEPTH-2)
- Flush_i  in  1  mispredict; discards every entry
- StallD_i  in  1  slot-1 decode stall (load-use); nothing is consumed
- Slot2Hold_i  in  1  slot-2 hazard from the controller; slot 2 is not consumed
- InstrD1_o, InstrD2_o  out  32  instructions presented to slots 1 and 2
- PCD1_o, PCD2_o  out  32  PCs of those instructions
- ValidD1_o, ValidD2_o  out  1  the slot holds a real buffered instruction
- Count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage is a circular array of {instr, pc} entries, with head pointer, tail pointer and count registers. Pointers wrap modulo DEPTH.
- Slot 1 reads entry[head]. Slot 2 reads entry[(head+1) mod DEPTH].
- ValidD1_o = (count >= 1). ValidD2_o = (count >= 2).
- When a slot is invalid, its instruction output is 32'h00000013 (addi x0,x0,0) and its PC output is 0.
- Push: when FetchValid_i & FetchReady_o & !Flush_i, write FetchInstr1_i/FetchPC_i at tail and FetchInstr2_i/FetchPC_i+4 at tail+1. Then tail += 2.
- Pop count:
  - 0 if StallD_i or !ValidD1_o.
  - Otherwise 1 if Slot2Hold_i or !ValidD2_o.
  - Otherwise 2.
- head advances by the pop count. count_next = count + push*2 − pop.
- Push and pop in the same cycle are both performed.
- FetchReady_o depends only on the registered count, never on the same-cycle pop.
- StallD_i has priority over Slot2Hold_i.
- Flush_i: head, tail and count all become 0 at the next edge. A push and a pop in the same cycle are both dropped.
- reset: same effect as Flush_i and takes priority over it. Entry contents need not be cleared.
- FetchValid_i while FetchReady_o=0: the pair is ignored. Fetch must hold its PC and re-present the pair.
- An arithmetic overflow of count is unreachable by construction. Under this rule the bench asserts count <= DEPTH.

## Timing
- Reset values:
  - Count_o=0, FetchReady_o=1.
  - ValidD1_o=ValidD2_o=0.
  - InstrD1_o=InstrD2_o=32'h00000013, PCD1_o=PCD2_o=0.
- Latency: a pair pushed at edge N is visible on the slot outputs during cycle N+1. There is no fetch-to-decode bypass.
- Slot outputs are combinational from the registered storage and head pointer. There is no combinational path from Fetch*_i to the slot outputs.
- Consumption happens at the edge that ends the cycle in which the outputs were presented.
- After a flush at edge N, the first pair pushed at edge N+1 is presented in cycle N+2.
- Throughput: 2 instructions per cycle sustained with no hazards and DEPTH >= 4.

## Test plan
- Reset, then push the pair PC=0x1000 (instrs 0x00500093, 0x00600113) -> next cycle ValidD1/ValidD2=1, PCD1=0x1000, PCD2=0x1004, Count=2. Pop 2 -> Count=0, slots show NOP with PC 0.
- Slot2Hold_i=1 with buffer {0x1000,0x1004,0x1008,0x100C} -> next cycle PCD1=0x1004, PCD2=0x1008, Count=3.
- StallD_i=1 together with Slot2Hold_i=1 and a push -> head unchanged, Count rises by 2, outputs identical the next cycle.
- Fill to DEPTH=8 with decode stalled -> FetchReady_o=0 at Count=7 and 8. A FetchValid_i pair presented there is dropped, Count stays 8. Release the stall -> PCs drain in order across the pointer wrap.
- Count=5 with Flush_i=1, a push and a pop all in the same cycle -> Count=0, ValidD1=0. The pair pushed on the next cycle (PC=0x2000) appears on slot 1 two cycles after the flush.
- Count=1 with no hold -> pop 1 only. ValidD2_o stays 0 throughout, and InstrD2_o=32'h00000013.
